// File: rtl/ie_rd_serializer.sv
// ie_rd_serializer
//   Sits after the MTP interface engine. IE read words are captured on word_done,
//   buffered in a small FIFO and shifted MSB-first to the backscatter encoder.
//   The encoder takes one bit per bit_req while tx_vld is high. After IE job_done,
//   the frame ends once the FIFO has drained.
//   Optional feature macro: RD_SER_CRC16_APPEND_EN. When it is defined, the
//   ones-complement of a CRC-16/CCITT over all sent data bits is appended before
//   the frame ends.
module ie_rd_serializer #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2,
   parameter int WORD_W     = 16
) (
   input  logic              DOUB_BLF,
   input  logic              rst_n,
   input  logic              new_cmd,
   input  logic              tx_start,
   input  logic              word_done,
   input  logic              job_done,
   input  logic [WORD_W-1:0] mtp_data,
   input  logic              bit_req,
   output logic              tx_bit,
   output logic              tx_vld,
   output logic              tx_done,
   output logic              tx_busy,
   output logic              fifo_full,
   output logic              overflow
);

   localparam int CNT_W  = $clog2(WORD_W);
   localparam int LAST_I = WORD_W - 1;

   localparam logic [CNT_W-1:0]   BIT_LAST = LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0]   BIT_ONE  = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
   localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
   localparam logic [FIFO_AW:0]   CNT_FULL = FIFO_DEPTH[FIFO_AW:0];

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
`ifdef RD_SER_CRC16_APPEND_EN
   localparam logic [2:0] S_CRC   = 3'd3;
`endif
   localparam logic [2:0] S_DONE  = 3'd4;

`ifdef RD_SER_CRC16_APPEND_EN
   // One MSB-first step of CRC-16/CCITT (poly 0x1021).
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   // Synchronisers and edge flops for the IE handshakes
   logic wd_s1_q, wd_s2_q, wd_s3_q;
   logic jd_s1_q, jd_s2_q, jd_s3_q;
   logic push, job_rise;

   // FIFO storage and bookkeeping
   logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               fifo_empty, full_int, pop, wr_en, drop;
   logic [WORD_W-1:0]  head;

   // Control state
   logic [2:0]        state_q, state_d;
   logic              job_end_q, overflow_q;
   logic              frame_end;

   // Shift datapath
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
`ifdef RD_SER_CRC16_APPEND_EN
   logic [15:0]       crc_q, crc_d;
`endif

   // Double-flop each async IE signal, plus a third flop for edge detection
   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         wd_s1_q <= 1'b0;
         wd_s2_q <= 1'b0;
         wd_s3_q <= 1'b0;
         jd_s1_q <= 1'b0;
         jd_s2_q <= 1'b0;
         jd_s3_q <= 1'b0;
      end else begin
         wd_s1_q <= word_done;
         wd_s2_q <= wd_s1_q;
         wd_s3_q <= wd_s2_q;
         jd_s1_q <= job_done;
         jd_s2_q <= jd_s1_q;
         jd_s3_q <= jd_s2_q;
      end
   end

   assign push     = wd_s2_q & ~wd_s3_q;
   assign job_rise = jd_s2_q & ~jd_s3_q;

   assign fifo_empty = (count_q == '0);
   assign full_int   = (count_q == CNT_FULL);
   assign head       = mem_q[rd_ptr_q];
   assign pop        = (state_q == S_WAIT) & ~fifo_empty;
   // A simultaneous pop frees a slot, so a push at full is only dropped without one.
   assign drop       = push & full_int & ~pop;
   assign wr_en      = push & ~drop & ~new_cmd;
   assign frame_end  = (state_q == S_WAIT) & fifo_empty & job_end_q;

   // FIFO word storage: data only, no reset needed
   always_ff @(posedge DOUB_BLF) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= mtp_data;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (new_cmd) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky flags: job end seen, and word dropped on a full FIFO
   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         job_end_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else if (new_cmd) begin
         job_end_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (state_q == S_DONE) begin
            job_end_q <= 1'b0;
         end else if (job_rise) begin
            job_end_q <= 1'b1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else if (new_cmd) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; pending data always wins over the end of job
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!fifo_empty) begin
               state_d = S_SHIFT;
            end else if (job_end_q) begin
`ifdef RD_SER_CRC16_APPEND_EN
               state_d = S_CRC;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_SHIFT: begin
            if (bit_req && (bit_cnt_q == '0)) begin
               state_d = S_WAIT;
            end
         end
`ifdef RD_SER_CRC16_APPEND_EN
         S_CRC: begin
            if (bit_req && (bit_cnt_q == '0)) begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      tx_vld  = 1'b0;
      tx_bit  = 1'b0;
      tx_done = 1'b0;
      tx_busy = 1'b1;
      case (state_q)
         S_IDLE: begin
            tx_busy = 1'b0;
         end
         S_SHIFT: begin
            tx_vld = 1'b1;
            tx_bit = shreg_q[WORD_W-1];
         end
`ifdef RD_SER_CRC16_APPEND_EN
         S_CRC: begin
            tx_vld = 1'b1;
            tx_bit = shreg_q[WORD_W-1];
         end
`endif
         S_DONE: begin
            tx_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign fifo_full = full_int;
   assign overflow  = overflow_q;

   // Shift register next value: load a word (or the CRC), or shift on a consumed bit
   always_comb begin
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (pop) begin
         shreg_d   = head;
         bit_cnt_d = BIT_LAST;
`ifdef RD_SER_CRC16_APPEND_EN
      end else if (frame_end) begin
         shreg_d   = ~crc_q;
         bit_cnt_d = BIT_LAST;
`endif
      end else if (tx_vld && bit_req) begin
         shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q - BIT_ONE;
      end
   end

   // Shift register and bit counter: pure datapath, qualified by the FSM
   always_ff @(posedge DOUB_BLF) begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
   end

`ifdef RD_SER_CRC16_APPEND_EN
   // CRC next value: only data bits are folded in; cleared at frame end
   always_comb begin
      crc_d = crc_q;
      if (state_q == S_DONE) begin
         crc_d = 16'hFFFF;
      end else if ((state_q == S_SHIFT) && bit_req) begin
         crc_d = crc16_step(crc_q, shreg_q[WORD_W-1]);
      end
   end

   // CRC register
   always_ff @(posedge DOUB_BLF or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 16'hFFFF;
      end else if (new_cmd) begin
         crc_q <= 16'hFFFF;
      end else begin
         crc_q <= crc_d;
      end
   end
`else
   // frame_end only steers the FSM when no CRC trailer is appended
   logic unused_frame_end;
   assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_ie_rd_serializer.sv
// Testbench for ie_rd_serializer. The reference model turns the list of accepted
// words into the expected serial bit stream (MSB-first, plus the complemented
// CRC-16 trailer when RD_SER_CRC16_APPEND_EN is defined).
module tb_ie_rd_serializer;

   logic        DOUB_BLF = 1'b0;
   logic        rst_n, new_cmd, tx_start, word_done, job_done, bit_req;
   logic [15:0] mtp_data;
   logic        tx_bit, tx_vld, tx_done, tx_busy, fifo_full, overflow;

   ie_rd_serializer dut (
      .DOUB_BLF (DOUB_BLF),
      .rst_n    (rst_n),
      .new_cmd  (new_cmd),
      .tx_start (tx_start),
      .word_done(word_done),
      .job_done (job_done),
      .mtp_data (mtp_data),
      .bit_req  (bit_req),
      .tx_bit   (tx_bit),
      .tx_vld   (tx_vld),
      .tx_done  (tx_done),
      .tx_busy  (tx_busy),
      .fifo_full(fifo_full),
      .overflow (overflow)
   );

   always #5 DOUB_BLF = ~DOUB_BLF;

   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          req_pct = 100;
   int          done_cnt = 0;
   bit          rx_q[$];
   bit          exp_q[$];
   logic [15:0] mw[$];

   // Monitor: a bit is consumed when tx_vld and bit_req are both high at the edge
   always @(negedge DOUB_BLF) begin
      if (rst_n) begin
         if (tx_vld && bit_req) rx_q.push_back(tx_bit);
         if (tx_done) done_cnt++;
      end
   end

   // Reference model: expected stream from the accepted words
   function automatic void build_exp();
      logic [15:0] c;
      logic        fb;
      bit          b;
      c = 16'hFFFF;
      exp_q.delete();
      foreach (mw[k]) begin
         for (int i = 15; i >= 0; i--) begin
            b = mw[k][i];
            exp_q.push_back(b);
            fb = c[15] ^ b;
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
`ifdef RD_SER_CRC16_APPEND_EN
      c = ~c;
      for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
`endif
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         if (rx_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(posedge DOUB_BLF);
      #1;
      if (req_pct >= 100) bit_req = 1'b1;
      else if (req_pct <= 0) bit_req = 1'b0;
      else bit_req = ($urandom_range(99) < req_pct);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push_word(input logic [15:0] w);
      mtp_data  = w;
      word_done = 1'b1;
      ticks(2);
      word_done = 1'b0;
      ticks(3);
   endtask

   task automatic start_frame();
      rx_q.delete();
      done_cnt = 0;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin
            timeout = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic end_frame();
      job_done = 1'b0;
      ticks(4);
   endtask

   task automatic test_reset();
      bit to;
      int d;
      rst_n = 1'b0; new_cmd = 0; tx_start = 0; word_done = 0; job_done = 0;
      bit_req = 0; mtp_data = 0;
      ticks(3);
      rst_n = 1'b1;
      ticks(2);
      for (int i = 0; i < 5; i++) push_word(16'h1111 * i[15:0]);
      rst_n = 1'b0;
      #2;
      vec_cnt++;
      if ({tx_bit, tx_vld, tx_done, tx_busy, fifo_full, overflow} !== 6'b0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got %b, expected 000000",
                  {tx_bit, tx_vld, tx_done, tx_busy, fifo_full, overflow});
      end
      tick();
      rst_n = 1'b1;
      ticks(5);
      vec_cnt++;
      if (tx_busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_idle_busy: got %b, expected 0", tx_busy);
      end
      // The FIFO must be empty: the frame carries no data words
      mw.delete();
      build_exp();
      start_frame();
      job_done = 1'b1;
      wait_done(500, to);
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size()) begin
         err_cnt++;
         $display("FAIL reset_empty_frame: got %0d bits (timeout %0d), expected %0d",
                  rx_q.size(), to, exp_q.size());
      end
      d = first_diff();
      vec_cnt++;
      if (d !== -1) begin
         err_cnt++;
         $display("FAIL reset_empty_bits: bit %0d got %0d, expected %0d", d, rx_q[d], exp_q[d]);
      end
      end_frame();
   endtask

   task automatic test_single_word();
      bit to;
      int d;
      req_pct = 100;
      mw.delete();
      mw.push_back(16'hA5C3);
      build_exp();
      push_word(16'hA5C3);
      start_frame();
      vec_cnt++;
      if (tx_busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL single_busy: got %b, expected 1", tx_busy);
      end
      job_done = 1'b1;
      wait_done(500, to);
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size()) begin
         err_cnt++;
         $display("FAIL single_len: got %0d bits (timeout %0d), expected %0d",
                  rx_q.size(), to, exp_q.size());
      end
      d = first_diff();
      vec_cnt++;
      if (d !== -1) begin
         err_cnt++;
         $display("FAIL single_bits: bit %0d got %0d, expected %0d", d, rx_q[d], exp_q[d]);
      end
      ticks(2);
      vec_cnt++;
      if (done_cnt !== 1 || tx_busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_done: got %0d pulses busy %b, expected 1 pulse busy 0",
                  done_cnt, tx_busy);
      end
      end_frame();
   endtask

   task automatic test_crc_zero();
      bit          to;
      logic [15:0] tail;
      req_pct = 100;
      push_word(16'h0000);
      start_frame();
      job_done = 1'b1;
      wait_done(500, to);
`ifdef RD_SER_CRC16_APPEND_EN
      tail = '0;
      for (int i = 16; i < 32 && i < rx_q.size(); i++) tail = {tail[14:0], rx_q[i]};
      vec_cnt++;
      if (to || rx_q.size() !== 32 || tail !== 16'hE2F0) begin
         err_cnt++;
         $display("FAIL crc_zero: got %0d bits tail %h, expected 32 bits tail e2f0",
                  rx_q.size(), tail);
      end
`else
      tail = '1;
      for (int i = 0; i < 16 && i < rx_q.size(); i++) tail = {tail[14:0], rx_q[i]};
      vec_cnt++;
      if (to || rx_q.size() !== 16 || tail !== 16'h0000) begin
         err_cnt++;
         $display("FAIL crc_zero: got %0d bits word %h, expected 16 bits word 0000",
                  rx_q.size(), tail);
      end
`endif
      end_frame();
   endtask

   task automatic test_overflow();
      bit to;
      int d;
      req_pct = 100;
      mw.delete();
      for (int i = 0; i < 4; i++) begin
         mw.push_back(16'($urandom));
         push_word(mw[i]);
      end
      vec_cnt++;
      if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL ovf_full4: got full %b ovf %b, expected full 1 ovf 0", fifo_full, overflow);
      end
      push_word(16'hDEAD);
      vec_cnt++;
      if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_drop5: got full %b ovf %b, expected full 1 ovf 1", fifo_full, overflow);
      end
      build_exp();
      start_frame();
      job_done = 1'b1;
      wait_done(1000, to);
      d = first_diff();
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size() || d !== -1) begin
         err_cnt++;
         $display("FAIL ovf_frame: got %0d bits first diff %0d, expected %0d bits no diff",
                  rx_q.size(), d, exp_q.size());
      end
      end_frame();
      vec_cnt++;
      if (overflow !== 1'b1) begin
         err_cnt++;
         $display("FAIL ovf_sticky: got %b, expected 1", overflow);
      end
      new_cmd = 1'b1;
      tick();
      new_cmd = 1'b0;
      vec_cnt++;
      if (overflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL ovf_clear: got %b, expected 0", overflow);
      end
   endtask

   task automatic test_stall();
      bit to;
      int d;
      int cyc;
      bit hold_ok;
      req_pct = 100;
      mw.delete();
      for (int i = 0; i < 2; i++) begin
         mw.push_back(16'($urandom));
         push_word(mw[i]);
      end
      build_exp();
      start_frame();
      job_done = 1'b1;
      cyc = 0;
      while (rx_q.size() < 20 && cyc < 200) begin
         tick();
         cyc++;
      end
      req_pct = 0;
      bit_req = 1'b0;
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_vld !== 1'b1 || tx_bit !== exp_q[rx_q.size()]) hold_ok = 1'b0;
      end
      vec_cnt++;
      if (!hold_ok || cyc >= 200) begin
         err_cnt++;
         $display("FAIL stall_hold: got vld %b bit %b, expected vld 1 bit %0d",
                  tx_vld, tx_bit, exp_q[rx_q.size()]);
      end
      req_pct = 100;
      wait_done(500, to);
      d = first_diff();
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size() || d !== -1) begin
         err_cnt++;
         $display("FAIL stall_frame: got %0d bits first diff %0d, expected %0d bits no diff",
                  rx_q.size(), d, exp_q.size());
      end
      end_frame();
   endtask

   task automatic test_new_cmd();
      bit to;
      int d;
      int cyc;
      req_pct = 100;
      mw.delete();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) mw.push_back(16'($urandom));
         push_word(i < 4 ? mw[i] : 16'h5A5A);
      end
      build_exp();
      start_frame();
      cyc = 0;
      while (rx_q.size() < 23 && cyc < 200) begin
         tick();
         cyc++;
      end
      new_cmd = 1'b1;
      tick();
      new_cmd = 1'b0;
      vec_cnt++;
      if ({tx_vld, tx_busy, fifo_full, overflow} !== 4'b0 || cyc >= 200) begin
         err_cnt++;
         $display("FAIL newcmd_idle: got vld/busy/full/ovf %b, expected 0000",
                  {tx_vld, tx_busy, fifo_full, overflow});
      end
      d = first_diff();
      vec_cnt++;
      if (d !== -1) begin
         err_cnt++;
         $display("FAIL newcmd_prefix: bit %0d got %0d, expected %0d", d, rx_q[d], exp_q[d]);
      end
      ticks(5);
      vec_cnt++;
      if (done_cnt !== 0) begin
         err_cnt++;
         $display("FAIL newcmd_nodone: got %0d pulses, expected 0", done_cnt);
      end
      // FIFO was emptied: the next frame carries no data words
      mw.delete();
      build_exp();
      start_frame();
      job_done = 1'b1;
      wait_done(500, to);
      d = first_diff();
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size() || d !== -1) begin
         err_cnt++;
         $display("FAIL newcmd_empty: got %0d bits first diff %0d, expected %0d bits",
                  rx_q.size(), d, exp_q.size());
      end
      end_frame();
   endtask

   task automatic test_random_preload();
      bit to;
      int d;
      int n;
      for (int it = 0; it < 3; it++) begin
         req_pct = 50;
         n = $urandom_range(4, 1);
         mw.delete();
         for (int i = 0; i < n; i++) begin
            mw.push_back(16'($urandom));
            push_word(mw[i]);
         end
         build_exp();
         start_frame();
         job_done = 1'b1;
         wait_done(2000, to);
         d = first_diff();
         vec_cnt++;
         if (to || rx_q.size() !== exp_q.size() || d !== -1) begin
            err_cnt++;
            $display("FAIL rand_preload_%0d: got %0d bits first diff %0d, expected %0d bits",
                     it, rx_q.size(), d, exp_q.size());
         end
         ticks(2);
         vec_cnt++;
         if (done_cnt !== 1) begin
            err_cnt++;
            $display("FAIL rand_done_%0d: got %0d pulses, expected 1", it, done_cnt);
         end
         end_frame();
      end
   endtask

   task automatic test_back_to_back_stream();
      bit to;
      int d;
      req_pct = 75;
      mw.delete();
      start_frame();
      for (int i = 0; i < 6; i++) begin
         mw.push_back(16'($urandom));
         push_word(mw[i]);
         ticks(40);
      end
      build_exp();
      job_done = 1'b1;
      wait_done(2000, to);
      d = first_diff();
      vec_cnt++;
      if (to || rx_q.size() !== exp_q.size() || d !== -1) begin
         err_cnt++;
         $display("FAIL stream: got %0d bits first diff %0d, expected %0d bits",
                  rx_q.size(), d, exp_q.size());
      end
      vec_cnt++;
      if (overflow !== 1'b0) begin
         err_cnt++;
         $display("FAIL stream_ovf: got %b, expected 0", overflow);
      end
      end_frame();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_crc_zero();
      test_overflow();
      test_stall();
      test_new_cmd();
      test_random_preload();
      test_back_to_back_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
